// File: rtl/peg_prbs_byte_chkr.sv
// PRBS-15 (x^15+x^14+1) receive checker: compares framed bytes against a locally
// seeded sequence and reports per-byte errors, per-frame results and saturating counters.
module peg_prbs_byte_chkr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [14:0]      cfg_seed,
    input  logic             cfg_en,
    input  logic             cnt_clr,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [7:0]       in_data,
    output logic             byte_err,
    output logic [7:0]       exp_data,
    output logic             frm_done,
    output logic             frm_pass,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] frm_err_cnt,
    output logic [CNT_W-1:0] byte_err_cnt,
    output logic             busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    localparam logic [14:0] SEED_DFLT = 15'h7FFF;

    // Eight LFSR steps unrolled; the first generated bit lands in byte bit 7.
    function automatic logic [22:0] prbs8(input logic [14:0] s_in);
        logic [14:0] s;
        logic [7:0]  v;
        logic        b;
        s = s_in;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            b = s[14] ^ s[13];
            s = {s[13:0], b};
            v = {v[6:0], b};
        end
        return {v, s};
    endfunction

    // Clear has priority over a same-cycle increment; counting stops at all-ones.
    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (c != {CNT_W{1'b1}}))
            return c + CNT_W'(1);
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [14:0]       lfsr_q, lfsr_d;
    logic              flag_q, flag_d;
    logic              byte_err_q, byte_err_d;
    logic [7:0]        exp_q, exp_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  fcnt_q, fecnt_q, becnt_q;

    logic [14:0] seed_eff, sop_state, nxt_state;
    logic [7:0]  sop_byte, nxt_byte;
    logic        mism, inc_f, inc_fe, inc_b;

    assign seed_eff = (cfg_seed == 15'h0000) ? SEED_DFLT : cfg_seed;
    assign {sop_byte, sop_state} = prbs8(seed_eff);
    assign {nxt_byte, nxt_state} = prbs8(lfsr_q);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        flag_d     = flag_q;
        byte_err_d = 1'b0;
        exp_d      = exp_q;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        mism       = 1'b0;
        inc_f      = 1'b0;
        inc_fe     = 1'b0;
        inc_b      = 1'b0;

        if (!cfg_en) begin
            state_d = S_IDLE;
        end else if (in_valid) begin
            if (in_sop) begin
                // A SOP inside a running frame closes that frame as failed first.
                if (state_q == S_CHECK) begin
                    done_d = 1'b1;
                    inc_f  = 1'b1;
                    inc_fe = 1'b1;
                end
                mism       = (in_data != sop_byte);
                lfsr_d     = sop_state;
                exp_d      = sop_byte;
                byte_err_d = mism;
                inc_b      = mism;
                flag_d     = mism;
                if (in_eop) begin
                    done_d  = 1'b1;
                    pass_d  = !mism;
                    inc_f   = 1'b1;
                    inc_fe  = inc_fe | mism;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CHECK;
                end
            end else if (state_q == S_CHECK) begin
                mism       = (in_data != nxt_byte);
                lfsr_d     = nxt_state;
                exp_d      = nxt_byte;
                byte_err_d = mism;
                inc_b      = mism;
                flag_d     = flag_q | mism;
                if (in_eop) begin
                    done_d  = 1'b1;
                    pass_d  = !(flag_q | mism);
                    inc_f   = 1'b1;
                    inc_fe  = flag_q | mism;
                    state_d = S_IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_DFLT;
            flag_q     <= 1'b0;
            byte_err_q <= 1'b0;
            exp_q      <= 8'h00;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fcnt_q     <= '0;
            fecnt_q    <= '0;
            becnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            flag_q     <= flag_d;
            byte_err_q <= byte_err_d;
            exp_q      <= exp_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fcnt_q     <= cnt_upd(fcnt_q, inc_f, cnt_clr);
            fecnt_q    <= cnt_upd(fecnt_q, inc_fe, cnt_clr);
            becnt_q    <= cnt_upd(becnt_q, inc_b, cnt_clr);
        end
    end

    assign byte_err     = byte_err_q;
    assign exp_data     = exp_q;
    assign frm_done     = done_q;
    assign frm_pass     = pass_q;
    assign frm_cnt      = fcnt_q;
    assign frm_err_cnt  = fecnt_q;
    assign byte_err_cnt = becnt_q;
    assign busy         = (state_q == S_CHECK);

endmodule

// File: tb/tb_peg_prbs_byte_chkr.sv
// Bench for peg_prbs_byte_chkr: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_peg_prbs_byte_chkr;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [14:0]      cfg_seed = 15'h7FFF;
    logic             cfg_en = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sop = 1'b0;
    logic             in_eop = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             byte_err;
    logic [7:0]       exp_data;
    logic             frm_done;
    logic             frm_pass;
    logic [CNT_W-1:0] frm_cnt;
    logic [CNT_W-1:0] frm_err_cnt;
    logic [CNT_W-1:0] byte_err_cnt;
    logic             busy;

    int total = 0;
    int bad   = 0;

    peg_prbs_byte_chkr #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_seed(cfg_seed), .cfg_en(cfg_en), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .byte_err(byte_err), .exp_data(exp_data), .frm_done(frm_done), .frm_pass(frm_pass),
        .frm_cnt(frm_cnt), .frm_err_cnt(frm_err_cnt), .byte_err_cnt(byte_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // n-th byte (0-based) of the sequence started from seed, generated one bit at a time.
    function automatic logic [7:0] prbs_nth(input logic [14:0] seed, input int n);
        logic [14:0] s;
        logic [7:0]  v;
        logic        b;
        s = seed;
        v = 8'h00;
        for (int k = 0; k <= n; k++) begin
            for (int j = 0; j < 8; j++) begin
                b = s[14] ^ s[13];
                s = {s[13:0], b};
                v = {v[6:0], b};
            end
        end
        return v;
    endfunction

    function automatic int bump(input int c, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && c < CNT_MAX) return c + 1;
        return c;
    endfunction

    // Reference model: tracks frame position (seed + byte index) rather than LFSR state.
    bit          m_in_frame = 0;
    logic [14:0] m_seed = 15'h7FFF;
    int          m_idx = 0;
    bit          m_flag = 0;
    bit          e_err = 0;
    logic [7:0]  e_exp = 8'h00;
    bit          e_done = 0;
    bit          e_pass = 0;
    int          e_fc = 0, e_fec = 0, e_bc = 0;

    always @(posedge clk or negedge rst_n) begin
        bit ib, ifr, ife, mm;
        if (!rst_n) begin
            m_in_frame = 0; m_idx = 0; m_flag = 0;
            e_err = 0; e_exp = 8'h00; e_done = 0; e_pass = 0;
            e_fc = 0; e_fec = 0; e_bc = 0;
        end else begin
            ib = 0; ifr = 0; ife = 0;
            e_err = 0; e_done = 0; e_pass = 0;
            if (!cfg_en) begin
                m_in_frame = 0;
            end else if (in_valid && (in_sop || m_in_frame)) begin
                if (in_sop) begin
                    if (m_in_frame) begin
                        e_done = 1; e_pass = 0; ifr = 1; ife = 1;
                    end
                    m_seed = (cfg_seed == 15'h0) ? 15'h7FFF : cfg_seed;
                    m_idx  = 0;
                    m_flag = 0;
                end
                e_exp = prbs_nth(m_seed, m_idx);
                m_idx++;
                mm = (in_data != e_exp);
                e_err = mm; ib = mm;
                m_flag = m_flag | mm;
                m_in_frame = 1;
                if (in_eop) begin
                    e_done = 1; e_pass = !m_flag; ifr = 1; ife = ife | m_flag;
                    m_in_frame = 0;
                end
            end
            e_fc  = bump(e_fc, ifr, cnt_clr);
            e_fec = bump(e_fec, ife, cnt_clr);
            e_bc  = bump(e_bc, ib, cnt_clr);
        end
    end

    always @(negedge clk) begin
        check("outputs",
              64'({byte_err, exp_data, frm_done, frm_pass & frm_done, busy,
                   frm_cnt, frm_err_cnt, byte_err_cnt}),
              64'({e_err, e_exp, e_done, e_pass & e_done, m_in_frame,
                   CNT_W'(e_fc), CNT_W'(e_fec), CNT_W'(e_bc)}));
    end

    task automatic cycle(input logic v, input logic s, input logic e,
                         input logic [7:0] d, input logic clr);
        @(negedge clk);
        in_valid = v; in_sop = s; in_eop = e; in_data = d; cnt_clr = clr;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        check("clr_cnt", 64'({frm_cnt, frm_err_cnt, byte_err_cnt}), 64'(0));
    endtask

    initial begin
        check("pin_byte0", 64'(prbs_nth(15'h7FFF, 0)), 64'h00);
        check("pin_byte1", 64'(prbs_nth(15'h7FFF, 1)), 64'h02);

        repeat (2) @(negedge clk);
        check("rst_outs", 64'({byte_err, exp_data, frm_done, frm_pass, busy}), 64'(0));
        check("rst_cnts", 64'({frm_cnt, frm_err_cnt, byte_err_cnt}), 64'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        cfg_en = 1'b1;
        idle();

        // Clean two-byte frame.
        cycle(1, 1, 0, 8'h00, 0);
        cycle(1, 0, 1, 8'h02, 0);
        check("clean_busy", 64'(busy), 64'(1));
        idle();
        check("clean_done", 64'({frm_done, frm_pass, byte_err}), 64'b110);
        check("clean_fcnt", 64'(frm_cnt), 64'(1));
        check("clean_busy_lo", 64'(busy), 64'(0));

        // Single-bit error, seed 0 behaves as 7FFF.
        clear();
        cfg_seed = 15'h0000;
        cycle(1, 1, 0, 8'h00, 0);
        cycle(1, 0, 1, 8'h03, 0);
        idle();
        check("err_pulse", 64'({byte_err, exp_data}), 64'h102);
        check("err_frm", 64'({frm_done, frm_pass}), 64'b10);
        check("err_cnts", 64'({frm_err_cnt, byte_err_cnt}), 64'h0001_0001);

        // Single-byte frame never raises busy.
        clear();
        cfg_seed = 15'h7FFF;
        cycle(1, 1, 1, 8'h00, 0);
        idle();
        check("sbf_done", 64'({frm_done, frm_pass, busy}), 64'b110);

        // Truncated frame followed by a good frame.
        clear();
        cycle(1, 1, 0, prbs_nth(15'h7FFF, 0), 0);
        cycle(1, 0, 0, prbs_nth(15'h7FFF, 1), 0);
        cycle(1, 0, 0, prbs_nth(15'h7FFF, 2), 0);
        cycle(1, 1, 0, prbs_nth(15'h7FFF, 0), 0);
        cycle(1, 0, 1, prbs_nth(15'h7FFF, 1), 0);
        check("trunc_close", 64'({frm_done, frm_pass, busy}), 64'b101);
        idle();
        check("trunc_second", 64'({frm_done, frm_pass}), 64'b11);
        check("trunc_cnts", 64'({frm_cnt, frm_err_cnt}), 64'h0002_0001);

        // cfg_en drop mid-frame: abandoned silently, stray data dropped.
        clear();
        cycle(1, 1, 0, 8'h00, 0);
        @(negedge clk);
        cfg_en = 1'b0; in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 8'h02;
        @(negedge clk);
        cfg_en = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 8'h55;
        check("dis_idle", 64'({frm_done, busy}), 64'b00);
        idle();
        check("dis_cnts", 64'({frm_cnt, byte_err_cnt}), 64'(0));

        // 64-byte frame with random valid gaps.
        clear();
        cfg_seed = 15'h1234;
        for (int i = 0; i < 64; i++) begin
            while ($urandom_range(0, 2) == 0) idle();
            cycle(1, i == 0, i == 63, prbs_nth(15'h1234, i), 0);
        end
        idle();
        check("gap_pass", 64'({frm_done, frm_pass}), 64'b11);
        check("gap_cnts", 64'({frm_cnt, byte_err_cnt}), 64'h0001_0000);

        // Reset in mid-frame.
        cfg_seed = 15'h7FFF;
        cycle(1, 1, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h02, 0);
        @(posedge clk); #2 rst_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(negedge clk);
        check("rst_mid", 64'({byte_err, exp_data, frm_done, busy, frm_cnt}), 64'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        idle();
        idle();
        check("rst_nodone", 64'(frm_done), 64'(0));
        cycle(1, 1, 0, 8'h00, 0);
        cycle(1, 0, 1, 8'h02, 0);
        idle();
        check("rst_next", 64'({frm_done, frm_pass, frm_cnt}), 64'h3_0001);

        // Saturation, then clear colliding with a mismatch.
        for (int i = 0; i < 70000; i++) cycle(1, 1, 1, 8'hFF, 0);
        idle();
        check("sat_becnt", 64'(byte_err_cnt), 64'hFFFF);
        check("sat_fecnt", 64'(frm_err_cnt), 64'hFFFF);
        cycle(1, 1, 1, 8'hFF, 1);
        idle();
        check("clr_vs_inc", 64'({byte_err, byte_err_cnt}), 64'h1_0000);

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peg_prbs_byte_chkr.md
# peg_prbs_byte_chkr

Synthesizable byte-stream checker that receives framed data and compares every byte against a locally generated PRBS-15 sequence. It is the receive-side counterpart of the TB's random-byte stimulus generation. A DUT-side or loopback path can be driven with PRBS payload, and this block reports per-byte mismatches, per-frame pass/fail and saturating statistics. It sits on the ingress side of a loopback datapath, and its status and counters are read by the register block.

## Interface
- `CNT_W`, default 16: width of each statistics counter.
- `clk`, input, 1: single clock for the whole block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_seed`, input, 15: LFSR seed, sampled on every SOP byte. A value of 0 is replaced by 15'h7FFF.
- `cfg_en`, input, 1: checker enable. While 0, input is ignored and the state machine is held in IDLE.
- `cnt_clr`, input, 1: single-cycle pulse that clears all counters.
- `in_valid`, input, 1: byte qualifier. The sink is always ready.
- `in_sop`, input, 1: first byte of a frame. Valid only with `in_valid`.
- `in_eop`, input, 1: last byte of a frame. Valid only with `in_valid`.
- `in_data`, input, 8: payload byte.
- `byte_err`, output, 1: one-cycle pulse when a checked byte mismatches.
- `exp_data`, output, 8: expected byte, registered alongside `byte_err`.
- `frm_done`, output, 1: one-cycle pulse when a frame ends.
- `frm_pass`, output, 1: frame result. Meaningful only while `frm_done` is 1.
- `frm_cnt`, output, `CNT_W`: frames completed, saturating.
- `frm_err_cnt`, output, `CNT_W`: failed frames, saturating.
- `byte_err_cnt`, output, `CNT_W`: mismatched bytes, saturating.
- `busy`, output, 1: 1 while the state machine is in CHECK.

## Operation
- **LFSR.** The LFSR is 15 bits, polynomial x^15+x^14+1.
  - Each output bit is b = s[14]^s[13]; the state then becomes s = {s[13:0], b}.
  - One byte uses 8 successive bits. The first bit generated goes to byte bit 7 (MSB first).
  - The next-byte value and next state are computed combinationally, 8 steps unrolled.
- **IDLE state.**
  - On `in_valid & in_sop & cfg_en`: compare `in_data` against the first byte of the seeded sequence.
  - Load the LFSR with the post-byte state.
  - Clear the frame-error flag, then set it if that byte mismatches.
  - Go to CHECK, or complete the frame immediately if `in_eop` is also 1.
  - Non-SOP bytes seen in IDLE are dropped silently; no counters change.
- **CHECK state.**
  - Each `in_valid` byte is compared against the next LFSR byte, and the LFSR advances.
  - A mismatch pulses `byte_err`, increments `byte_err_cnt` and sets the frame-error flag.
  - On `in_eop`: pulse `frm_done`, with `frm_pass` = !flag (including the EOP byte's own result). Increment `frm_cnt`, increment `frm_err_cnt` if the frame failed, and return to IDLE.
- **SOP while in CHECK.** The running frame is closed as failed: `frm_done`=1, `frm_pass`=0, both `frm_cnt` and `frm_err_cnt` increment. The new SOP byte is then processed exactly as in IDLE, in the same cycle.
- **`cfg_en` deasserted in CHECK.** Go to IDLE, with no `frm_done` and no counter update.
- **Counters.**
  - All counters saturate at all-ones.
  - `cnt_clr` wins over a same-cycle increment: the result is 0 and the increment is lost.
  - `cnt_clr` does not affect the state machine or LFSR.

## Timing
- Reset values:
  - All outputs are 0; `exp_data` is 8'h00.
  - The state machine is in IDLE and the LFSR holds 15'h7FFF.
- Latency: a byte accepted at cycle N produces `byte_err`/`exp_data` at N+1. An EOP accepted at N produces `frm_done`/`frm_pass` at N+1. Counters show the update at N+1.
- `busy` reflects the registered state: it rises the cycle after a non-EOP SOP and falls the cycle after EOP.
- Back-to-back frames (EOP at N, SOP at N+1) are supported with no gap.
- `in_valid`=0 cycles inside a frame are legal and leave the LFSR unchanged.
- Asynchronous reset mid-frame aborts the frame with no `frm_done`.

## Test plan
- **Clean frame.** Seed 15'h7FFF, 2-byte frame 8'h00, 8'h02 -> no `byte_err`; `frm_done`=1 with `frm_pass`=1 at EOP+1; `frm_cnt`=1.
- **Single-bit error.** Seed 0 (maps to 15'h7FFF), frame 8'h00, 8'h03 -> `byte_err` pulse with `exp_data`=8'h02; `byte_err_cnt`=1, `frm_err_cnt`=1, `frm_pass`=0.
- **Single-byte frame.** `in_sop`=`in_eop`=1, byte 8'h00, seed 15'h7FFF -> `frm_pass`=1 the next cycle; `busy` stays 0.
- **Truncated frame.** SOP, 3 correct bytes, then a new SOP of a correct frame -> first frame fails (`frm_err_cnt`=1); second frame passes; `frm_cnt`=2.
- **Saturation and clear.** Force 70000 mismatched bytes with `CNT_W`=16 -> `byte_err_cnt` holds 16'hFFFF. `cnt_clr` on the same cycle as a mismatch -> counter reads 0.
- **Gaps and reset.** Random `in_valid` gaps in a 64-byte frame -> pass. Assert `rst_n`=0 mid-frame -> all outputs 0 and no `frm_done`; the next frame is checked correctly.
